// File: rtl/ysyx_22050612_rf_pkg.sv
// rtl/ysyx_22050612_rf_pkg.sv - shared constants for the scoreboarded register file
package ysyx_22050612_rf_pkg;

    localparam int unsigned REG_ZERO       = 0;
    localparam int unsigned DEF_ADDR_WIDTH = 5;
    localparam int unsigned DEF_DATA_WIDTH = 64;

    function automatic int unsigned cnt_max(input int unsigned width);
        return (1 << width) - 1;
    endfunction

endpackage

// File: rtl/ysyx_22050612_regfile_sb_if.sv
// rtl/ysyx_22050612_regfile_sb_if.sv - read, issue and writeback bundle of the register file
interface ysyx_22050612_regfile_sb_if
    import ysyx_22050612_rf_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned NREAD      = 2
);
    logic [NREAD*ADDR_WIDTH-1:0] raddr;
    logic [NREAD*DATA_WIDTH-1:0] rdata;
    logic [NREAD-1:0]            rbusy;
    logic                        issue_valid;
    logic [ADDR_WIDTH-1:0]       issue_rd;
    logic                        issue_ready;
    logic                        wen;
    logic [ADDR_WIDTH-1:0]       waddr;
    logic [DATA_WIDTH-1:0]       wdata;
    logic                        flush;

    modport master (
        output raddr, issue_valid, issue_rd, wen, waddr, wdata, flush,
        input  rdata, rbusy, issue_ready
    );

    modport slave (
        input  raddr, issue_valid, issue_rd, wen, waddr, wdata, flush,
        output rdata, rbusy, issue_ready
    );
endinterface

// File: rtl/ysyx_22050612_rf_pending_cnt.sv
// rtl/ysyx_22050612_rf_pending_cnt.sv - in-flight writer counter for one register
module ysyx_22050612_rf_pending_cnt
    import ysyx_22050612_rf_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 inc,
    input  logic                 dec,
    input  logic                 flush,
    output logic [CNT_WIDTH-1:0] cnt,
    output logic                 at_max
);
    assign at_max = (cnt == CNT_WIDTH'(cnt_max(CNT_WIDTH)));

    // The issuer never raises inc at max without a matching dec, so no wrap guard is needed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (flush) begin
            cnt <= '0;
        end else if (inc && !dec) begin
            cnt <= cnt + CNT_WIDTH'(1);
        end else if (dec && !inc && cnt != '0) begin
            cnt <= cnt - CNT_WIDTH'(1);
        end
    end
endmodule

// File: rtl/ysyx_22050612_regfile_sb.sv
// rtl/ysyx_22050612_regfile_sb.sv - integer register file with write bypass and pending-write scoreboard
module ysyx_22050612_regfile_sb
    import ysyx_22050612_rf_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned NREAD      = 2,
    parameter int unsigned CNT_WIDTH  = 2
) (
    input logic clk,
    input logic rst_n,
    ysyx_22050612_regfile_sb_if.slave bus
);
    localparam int unsigned NREGS = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(REG_ZERO);

    logic [DATA_WIDTH-1:0] rf     [NREGS];
    logic [CNT_WIDTH-1:0]  cnt    [NREGS];
    logic [NREGS-1:0]      at_max;
    logic                  wr_act;
    logic                  issue_ok;

    assign wr_act = bus.wen && (bus.waddr != ZERO_IDX);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < NREGS; k++) begin
                rf[k] <= '0;
            end
        end else if (wr_act) begin
            rf[bus.waddr] <= bus.wdata;
        end
    end

    // A writeback landing on a saturated destination frees a slot in the same cycle.
    assign issue_ok = !((bus.issue_rd != ZERO_IDX) && at_max[bus.issue_rd] &&
                        !(bus.wen && bus.waddr == bus.issue_rd));
    assign bus.issue_ready = issue_ok;

    assign cnt[0]    = '0;
    assign at_max[0] = 1'b0;

    for (genvar r = 1; r < NREGS; r++) begin : g_cnt
        logic inc;
        logic dec;
        assign inc = bus.issue_valid && issue_ok && (bus.issue_rd == ADDR_WIDTH'(r));
        assign dec = bus.wen && (bus.waddr == ADDR_WIDTH'(r)) && (cnt[r] != '0);

        ysyx_22050612_rf_pending_cnt #(
            .CNT_WIDTH (CNT_WIDTH)
        ) u_cnt (
            .clk    (clk),
            .rst_n  (rst_n),
            .inc    (inc),
            .dec    (dec),
            .flush  (bus.flush),
            .cnt    (cnt[r]),
            .at_max (at_max[r])
        );
    end

    for (genvar i = 0; i < NREAD; i++) begin : g_rd
        logic [ADDR_WIDTH-1:0] ra;
        logic                  hit;
        assign ra  = bus.raddr[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign hit = bus.wen && (bus.waddr == ra);

        assign bus.rdata[i*DATA_WIDTH +: DATA_WIDTH] =
            (ra == ZERO_IDX) ? '0 : (hit ? bus.wdata : rf[ra]);

        // The last outstanding writer arriving now is served through the bypass, so no stall.
        assign bus.rbusy[i] = (cnt[ra] > CNT_WIDTH'(1)) ||
                              ((cnt[ra] == CNT_WIDTH'(1)) && !hit);
    end
endmodule

// File: tb/tb_ysyx_22050612_regfile_sb.sv
// tb/tb_ysyx_22050612_regfile_sb.sv - directed self-checking bench for the scoreboarded register file
module tb_ysyx_22050612_regfile_sb;
    logic clk;
    logic rst_n;
    int   tests;
    int   failed;

    ysyx_22050612_regfile_sb_if #(.ADDR_WIDTH(5), .DATA_WIDTH(64), .NREAD(2)) bus ();

    ysyx_22050612_regfile_sb #(
        .ADDR_WIDTH (5),
        .DATA_WIDTH (64),
        .NREAD      (2),
        .CNT_WIDTH  (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.issue_valid = 1'b0;
        bus.issue_rd    = 5'd0;
        bus.wen         = 1'b0;
        bus.waddr       = 5'd0;
        bus.wdata       = 64'h0;
        bus.flush       = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a1, input logic [4:0] a0);
        bus.raddr = {a1, a0};
    endtask

    task automatic wr(input logic [4:0] a, input logic [63:0] d);
        bus.wen   = 1'b1;
        bus.waddr = a;
        bus.wdata = d;
    endtask

    task automatic iss(input logic [4:0] a);
        bus.issue_valid = 1'b1;
        bus.issue_rd    = a;
    endtask

    initial begin
        tests  = 0;
        failed = 0;
        rst_n  = 1'b0;
        idle();
        rd(5'd0, 5'd0);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        chk("rst_rdata0", bus.rdata[63:0], 64'h0);
        chk("rst_rbusy", 64'(bus.rbusy), 64'h0);
        chk("rst_ready", 64'(bus.issue_ready), 64'h1);

        // reset clears stored data and discards a same-cycle write
        wr(5'd5, 64'hAA);
        tick();
        idle();
        rd(5'd0, 5'd5);
        #1;
        chk("x5_before_rst", bus.rdata[63:0], 64'hAA);
        rst_n = 1'b0;
        wr(5'd5, 64'hBB);
        tick();
        rst_n = 1'b1;
        idle();
        #1;
        chk("x5_after_rst", bus.rdata[63:0], 64'h0);
        chk("x5_rbusy_rst", 64'(bus.rbusy), 64'h0);
        chk("ready_rst", 64'(bus.issue_ready), 64'h1);

        // x0 ignores writes, issues and bypass
        wr(5'd0, 64'hFFFF);
        iss(5'd0);
        rd(5'd0, 5'd0);
        #1;
        chk("x0_bypass", bus.rdata[63:0], 64'h0);
        chk("x0_ready", 64'(bus.issue_ready), 64'h1);
        tick();
        idle();
        #1;
        chk("x0_read", bus.rdata[127:64], 64'h0);
        chk("x0_rbusy", 64'(bus.rbusy), 64'h0);

        // bypass on both ports
        wr(5'd3, 64'h11);
        tick();
        wr(5'd4, 64'h44);
        tick();
        wr(5'd6, 64'h66);
        tick();
        wr(5'd3, 64'h22);
        rd(5'd3, 5'd3);
        #1;
        chk("byp_p0", bus.rdata[63:0], 64'h22);
        chk("byp_p1", bus.rdata[127:64], 64'h22);
        tick();
        idle();
        #1;
        chk("byp_next_p0", bus.rdata[63:0], 64'h22);
        chk("byp_next_p1", bus.rdata[127:64], 64'h22);

        // two writers on x7, released by the second writeback
        iss(5'd7);
        tick();
        tick();
        idle();
        rd(5'd0, 5'd7);
        #1;
        chk("x7_busy2", 64'(bus.rbusy[0]), 64'h1);
        wr(5'd7, 64'h77);
        #1;
        chk("x7_busy_wb1", 64'(bus.rbusy[0]), 64'h1);
        tick();
        idle();
        #1;
        chk("x7_busy1", 64'(bus.rbusy[0]), 64'h1);
        wr(5'd7, 64'h78);
        #1;
        chk("x7_release", 64'(bus.rbusy[0]), 64'h0);
        chk("x7_bypass", bus.rdata[63:0], 64'h78);
        tick();
        idle();
        #1;
        chk("x7_idle_busy", 64'(bus.rbusy[0]), 64'h0);
        chk("x7_data", bus.rdata[63:0], 64'h78);

        // saturation on x9
        iss(5'd9);
        #1;
        chk("x9_ready0", 64'(bus.issue_ready), 64'h1);
        tick();
        tick();
        chk("x9_ready2", 64'(bus.issue_ready), 64'h1);
        tick();
        rd(5'd9, 5'd9);
        #1;
        chk("x9_sat_ready", 64'(bus.issue_ready), 64'h0);
        chk("x9_busy_both", 64'(bus.rbusy), 64'h3);
        wr(5'd9, 64'h99);
        #1;
        chk("x9_wb_ready", 64'(bus.issue_ready), 64'h1);
        tick();
        idle();
        iss(5'd9);
        #1;
        chk("x9_still_sat", 64'(bus.issue_ready), 64'h0);
        chk("x9_data", bus.rdata[63:0], 64'h99);
        tick();
        iss(5'd5);
        #1;
        chk("other_ready", 64'(bus.issue_ready), 64'h1);
        idle();

        // flush clears counts, overrides same-cycle issue, keeps same-cycle write
        iss(5'd4);
        tick();
        iss(5'd6);
        tick();
        idle();
        rd(5'd6, 5'd4);
        #1;
        chk("pre_flush_busy", 64'(bus.rbusy), 64'h3);
        bus.flush = 1'b1;
        iss(5'd10);
        wr(5'd6, 64'h67);
        tick();
        idle();
        #1;
        chk("flush_busy", 64'(bus.rbusy), 64'h0);
        chk("flush_x4", bus.rdata[63:0], 64'h44);
        chk("flush_x6", bus.rdata[127:64], 64'h67);
        rd(5'd9, 5'd10);
        #1;
        chk("flush_x10_x9_busy", 64'(bus.rbusy), 64'h0);
        iss(5'd9);
        #1;
        chk("flush_x9_ready", 64'(bus.issue_ready), 64'h1);
        idle();

        // late writeback after flush: data lands, count stays at zero
        wr(5'd4, 64'h55);
        tick();
        idle();
        rd(5'd0, 5'd4);
        iss(5'd4);
        #1;
        chk("late_x4", bus.rdata[63:0], 64'h55);
        chk("late_busy", 64'(bus.rbusy[0]), 64'h0);
        chk("late_ready", 64'(bus.issue_ready), 64'h1);
        tick();
        idle();
        #1;
        chk("late_one_pending", 64'(bus.rbusy[0]), 64'h1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
